// File: rtl/fetch_seq_ctrl_if.sv
// Bundle between the fetch sequencer and its surroundings: control inputs,
// memory read handshake, datapath strobes and the visible sequencer state.
interface fetch_seq_ctrl_if #(
  parameter int WORD_W = 16
);
  // Memory read handshake: mem_rd is held high for every T1 cycle as the
  // request; mem_ack is a single-cycle accept, and mem_rdata is valid only
  // in the cycle mem_ack is high. There is no back-pressure on the accept.
  logic              START;
  logic              HLT;
  logic              SC_CLR;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_rdata;
  logic              pc_inr;
  logic              ar_ld;
  logic [2:0]        bus_sel;
  logic              mem_rd;
  logic [WORD_W-1:0] ir;
  logic              i_bit;
  logic [7:0]        d;
  logic [15:0]       t;
  logic              running;
  logic              err;
  logic [2:0]        dbg_state;

  modport master (
    input  START, HLT, SC_CLR, mem_ack, mem_rdata,
    output pc_inr, ar_ld, bus_sel, mem_rd, ir, i_bit, d, t, running, err,
           dbg_state
  );

  modport slave (
    output START, HLT, SC_CLR, mem_ack, mem_rdata,
    input  pc_inr, ar_ld, bus_sel, mem_rd, ir, i_bit, d, t, running, err,
           dbg_state
  );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// Fetch/decode sequencer for the basic computer: AR<-PC, IR<-M[AR] with PC+1,
// decode, then hands timing steps T3..T15 to execute control until SC_CLR.
module fetch_seq_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int WORD_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input logic             CLK,
  input logic             CLR,
  fetch_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_EXEC = 3'd4
  } state_t;

  localparam int WCNT_W = $clog2(ACK_TIMEOUT + 1) + 1;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_PC   = 3'd2;
  localparam logic [2:0] SEL_IR   = 3'd5;

  state_t              state_q, state_d;
  logic                run_q, run_d;
  logic [3:0]          sc_q, sc_d;
  logic [WORD_W-1:0]   ir_q, ir_d;
  logic                ibit_q, ibit_d;
  logic [7:0]          d_q, d_d;
  logic                err_q, err_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;

  logic                pc_inr_c;
  logic                ar_ld_c;
  logic [2:0]          bus_sel_c;
  logic                mem_rd_c;
  logic [15:0]         t_c;
  logic [WCNT_W-1:0]   wcnt_inc;
  logic                timeout_hit;

  // Saturating so a disabled timeout never wraps the counter back to a match.
  assign wcnt_inc    = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (wcnt_inc == WCNT_W'(ACK_TIMEOUT));

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      run_q   <= 1'b0;
      sc_q    <= 4'd0;
      ir_q    <= '0;
      ibit_q  <= 1'b0;
      d_q     <= 8'd0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      sc_q    <= sc_d;
      ir_q    <= ir_d;
      ibit_q  <= ibit_d;
      d_q     <= d_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    sc_d      = sc_q;
    ir_d      = ir_q;
    ibit_d    = ibit_q;
    d_d       = d_q;
    err_d     = err_q;
    wcnt_d    = wcnt_q;
    pc_inr_c  = 1'b0;
    ar_ld_c   = 1'b0;
    bus_sel_c = SEL_NONE;
    mem_rd_c  = 1'b0;
    t_c       = 16'd0;

    case (state_q)
      ST_IDLE: begin
        sc_d = 4'd0;
        if (bus.START && !bus.HLT && !err_q) begin
          run_d   = 1'b1;
          state_d = ST_T0;
        end
      end
      ST_T0: begin
        bus_sel_c = SEL_PC;
        ar_ld_c   = 1'b1;
        t_c[0]    = 1'b1;
        wcnt_d    = '0;
        state_d   = ST_T1;
      end
      ST_T1: begin
        mem_rd_c = 1'b1;
        t_c[1]   = 1'b1;
        if (bus.mem_ack) begin
          pc_inr_c = 1'b1;
          ir_d     = bus.mem_rdata;
          state_d  = ST_T2;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          run_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d = wcnt_inc;
        end
      end
      ST_T2: begin
        // AR takes the address field of IR through the low bus bits.
        bus_sel_c = SEL_IR;
        ar_ld_c   = 1'b1;
        t_c[2]    = 1'b1;
        ibit_d    = ir_q[WORD_W-1];
        d_d       = 8'd1 << ir_q[ADDR_W +: 3];
        sc_d      = 4'd3;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        t_c[sc_q] = 1'b1;
        if (bus.SC_CLR) begin
          sc_d    = 4'd0;
          state_d = ST_T0;
        end else if (sc_q != 4'd15) begin
          sc_d = sc_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = 1'b0;
      end
    endcase

    // Halt wins over every other event this cycle and freezes the datapath.
    if (bus.HLT && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      run_d    = 1'b0;
      sc_d     = 4'd0;
      ir_d     = ir_q;
      ibit_d   = ibit_q;
      d_d      = d_q;
      err_d    = err_q;
      wcnt_d   = wcnt_q;
      pc_inr_c = 1'b0;
    end
  end

  assign bus.pc_inr    = run_q & pc_inr_c;
  assign bus.ar_ld     = run_q & ar_ld_c;
  assign bus.mem_rd    = run_q & mem_rd_c;
  assign bus.bus_sel   = run_q ? bus_sel_c : SEL_NONE;
  assign bus.t         = run_q ? t_c : 16'd0;
  assign bus.ir        = ir_q;
  assign bus.i_bit     = ibit_q;
  assign bus.d         = d_q;
  assign bus.running   = run_q;
  assign bus.err       = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Bench for fetch_seq_ctrl: directed fetch/halt/timeout/reset scenarios plus
// randomized fetch+execute rounds, with a scoreboard on the decoded instruction.
module tb_fetch_seq_ctrl;

  localparam int WORD_W = 16;

  logic CLK;
  logic CLR;

  fetch_seq_ctrl_if #(.WORD_W(WORD_W)) bus ();

  fetch_seq_ctrl #(
    .ADDR_W(12),
    .WORD_W(WORD_W),
    .ACK_TIMEOUT(4)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;
  int pc_cnt   = 0;
  int exp_fetches = 0;
  logic [WORD_W-1:0] last_ir = '0;
  logic [WORD_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on the first execute step
  always @(negedge CLK) begin
    logic [WORD_W-1:0] e;
    chk("t_onehot0", 32'($onehot0(bus.t)), 32'd1);
    if (bus.pc_inr === 1'b1) pc_cnt++;
    if (bus.t[3] === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL sb_underflow actual=T3 without fetch expected=no T3 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ir", bus.ir, e);
        chk("sb_i_bit", bus.i_bit, e[15]);
        chk("sb_d", bus.d, 32'(8'd1 << e[14:12]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_inputs();
    bus.START     = 1'b0;
    bus.HLT       = 1'b0;
    bus.SC_CLR    = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_t"}, bus.t, 0);
    chk({tag, "_bus_sel"}, bus.bus_sel, 0);
    chk({tag, "_ar_ld"}, bus.ar_ld, 0);
    chk({tag, "_pc_inr"}, bus.pc_inr, 0);
    chk({tag, "_mem_rd"}, bus.mem_rd, 0);
    chk({tag, "_ir"}, bus.ir, 0);
    chk({tag, "_i_bit"}, bus.i_bit, 0);
    chk({tag, "_d"}, bus.d, 0);
    chk({tag, "_running"}, bus.running, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  task automatic apply_clr();
    CLR = 1'b1;
    clr_inputs();
    repeat (2) cyc();
    @(negedge CLK);
    check_all_zero("reset");
    CLR = 1'b0;
    last_ir = '0;
  endtask

  task automatic do_start();
    cyc();
    clr_inputs();
    bus.START = 1'b1;
    @(negedge CLK);
    chk("idle_t", bus.t, 0);
    chk("idle_running", bus.running, 0);
  endtask

  // Covers T0, the T1 wait/ack cycles and T2; leaves the DUT entering EXEC.
  task automatic do_fetch(input int waits, input logic [WORD_W-1:0] w);
    cyc();
    clr_inputs();
    @(negedge CLK);
    chk("t0_t", bus.t, 16'h0001);
    chk("t0_bus_sel", bus.bus_sel, 2);
    chk("t0_ar_ld", bus.ar_ld, 1);
    chk("t0_running", bus.running, 1);
    for (int k = 0; k < waits; k++) begin
      cyc();
      @(negedge CLK);
      chk("t1_wait_t", bus.t, 16'h0002);
      chk("t1_wait_mem_rd", bus.mem_rd, 1);
      chk("t1_wait_pc_inr", bus.pc_inr, 0);
    end
    cyc();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = w;
    exp_q.push_back(w);
    exp_fetches++;
    last_ir = w;
    @(negedge CLK);
    chk("t1_ack_t", bus.t, 16'h0002);
    chk("t1_ack_pc_inr", bus.pc_inr, 1);
    chk("t1_bus_sel", bus.bus_sel, 0);
    cyc();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = WORD_W'($urandom);
    @(negedge CLK);
    chk("t2_t", bus.t, 16'h0004);
    chk("t2_bus_sel", bus.bus_sel, 5);
    chk("t2_ar_ld", bus.ar_ld, 1);
    chk("t2_pc_inr", bus.pc_inr, 0);
  endtask

  // n execute cycles, SC_CLR raised in the last one; T0 follows.
  task automatic do_exec(input int n);
    int s;
    for (int k = 0; k < n; k++) begin
      cyc();
      bus.mem_rdata = '0;
      bus.SC_CLR = (k == n - 1);
      s = (3 + k > 15) ? 15 : 3 + k;
      @(negedge CLK);
      chk("exec_t", bus.t, 32'(16'd1 << s));
      chk("exec_ar_ld", bus.ar_ld, 0);
      chk("exec_bus_sel", bus.bus_sel, 0);
    end
  endtask

  initial begin
    CLR = 1'b1;
    clr_inputs();
    apply_clr();

    // Zero-wait fetch, then an indirect fetch with three wait cycles
    do_start();
    do_fetch(0, 16'h7123);
    do_exec(3);
    do_fetch(3, 16'hB1A3);
    do_exec(3);
    chk("pc_inr_pulses_two", pc_cnt, 2);

    // Randomized fetch/execute rounds, including step-counter saturation
    repeat (12) begin
      do_fetch($urandom_range(0, 3), WORD_W'($urandom));
      do_exec($urandom_range(1, 16));
    end

    // Halt arriving together with the memory ack
    cyc();
    clr_inputs();
    @(negedge CLK);
    chk("hlt_t0_t", bus.t, 16'h0001);
    cyc();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hFFFF;
    bus.HLT       = 1'b1;
    @(negedge CLK);
    chk("hlt_pc_inr", bus.pc_inr, 0);
    cyc();
    clr_inputs();
    @(negedge CLK);
    chk("hlt_t", bus.t, 0);
    chk("hlt_running", bus.running, 0);
    chk("hlt_ir_kept", bus.ir, last_ir);
    chk("pc_inr_pulses", pc_cnt, exp_fetches);

    // Asynchronous clear in the middle of a T1 cycle
    do_start();
    cyc();
    clr_inputs();
    @(negedge CLK);
    cyc();
    @(negedge CLK);
    chk("aclr_pre_t", bus.t, 16'h0002);
    #2;
    CLR = 1'b1;
    #1;
    check_all_zero("aclr");
    cyc();
    CLR = 1'b0;
    last_ir = '0;

    // Memory timeout: four unacknowledged T1 cycles
    do_start();
    cyc();
    clr_inputs();
    @(negedge CLK);
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge CLK);
      chk("to_wait_t", bus.t, 16'h0002);
      chk("to_wait_err", bus.err, 0);
    end
    cyc();
    @(negedge CLK);
    chk("to_err", bus.err, 1);
    chk("to_running", bus.running, 0);
    chk("to_t", bus.t, 0);
    cyc();
    bus.START = 1'b1;
    cyc();
    bus.START = 1'b0;
    @(negedge CLK);
    chk("to_start_ignored_t", bus.t, 0);
    chk("to_start_ignored_running", bus.running, 0);
    chk("to_err_sticky", bus.err, 1);
    apply_clr();

    chk("sb_drained", exp_q.size(), 0);
    chk("pc_inr_total", pc_cnt, exp_fetches);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
- Instruction-fetch sequencer and timing generator for the Mano-style basic computer.
- Runs the fetch/decode cycle: AR<-PC, IR<-M[AR] with PC+1, then decode. It drives the program counter's increment strobe, the AR load, the common-bus source select and the memory read request.
- Holds IR, the I flip-flop and the decoded opcode, then hands timing steps T3+ to the execute control until execute requests a restart.

Parameters:
- ADDR_W, 12, address width; PC/AR width.
- WORD_W, 16, memory word and IR width.
- ACK_TIMEOUT, 15, maximum T1 wait cycles for mem_ack before error; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  asynchronous, active-high reset.
- START  in  1  sets run flip-flop S; starts fetch from IDLE.
- HLT  in  1  clears S; sequencer returns to IDLE.
- SC_CLR  in  1  from execute control: instruction done, begin next fetch.
- mem_ack  in  1  memory read data valid this cycle.
- mem_rdata  in  WORD_W  memory read data.
- pc_inr  out  1  increment strobe to the PC register.
- ar_ld  out  1  load strobe to AR, taken from the bus.
- bus_sel  out  3  common-bus source: 0 none, 1 AR, 2 PC, 5 IR.
- mem_rd  out  1  memory read request.
- ir  out  WORD_W  instruction register.
- i_bit  out  1  indirect flip-flop, IR[15] latched at T2.
- d  out  8  one-hot decode of IR[14:12]; valid from T3.
- t  out  16  one-hot timing signal; t[k] = step Tk.
- running  out  1  S flip-flop.
- err  out  1  sticky memory-timeout error.

Behaviour:
- CLR asserted, any time, asynchronously:
  - State goes to IDLE; S=0; SC=0; ir=0; i_bit=0; d=0; err=0; wait counter=0.
  - All strobes are 0, bus_sel=0, t=0.
- States: IDLE, T0, T1, T2, EXEC. Strobes are combinational from state, only when running=1.
- IDLE:
  - All strobes 0; t=0.
  - START=1 at edge n: S=1, and T0 is active in cycle n+1.
- T0:
  - bus_sel=2, ar_ld=1, t[0]=1.
  - Next state T1; wait counter cleared.
- T1:
  - mem_rd=1, t[1]=1, bus_sel=0.
  - While mem_ack=0: stay in T1; wait counter increments.
  - mem_ack=1 in the first T1 cycle is legal (zero wait).
  - On a cycle with mem_ack=1: ir<=mem_rdata at that edge; pc_inr=1 for exactly that cycle; next state T2.
  - pc_inr is never asserted in any other cycle. The PC increments exactly once per fetch.
- Timeout:
  - Applies only when ACK_TIMEOUT>0 and the wait counter reaches ACK_TIMEOUT with mem_ack=0.
  - Sets err=1, clears S, goes to IDLE.
  - err stays set until CLR; START is ignored while err=1.
- T2:
  - bus_sel=5, ar_ld=1 (AR<-IR[11:0] via bus low bits), t[2]=1.
  - i_bit<=ir[15]; d<=onehot(ir[14:12]).
  - Next state EXEC with SC=3.
- EXEC:
  - t[SC]=1; SC increments each cycle and saturates at 15.
  - SC_CLR=1 at an edge: next state T0, SC=0.
  - SC_CLR outside EXEC is ignored.
- HLT=1 at an edge, in any non-IDLE state:
  - S=0, next state IDLE.
  - HLT has priority over SC_CLR and mem_ack in the same cycle. ir is not updated and pc_inr is forced 0 in that cycle.
- START while running: ignored. START and HLT in the same cycle from IDLE: stay IDLE.
- mem_ack outside T1 is ignored. mem_rdata is sampled only on an accepted ack.
- t is one-hot or all-zero at all times.

Test Plan:
- Reset then START, mem_ack held 1 -> t[0], t[1], t[2], t[3] on consecutive cycles; bus_sel 2,0,5; ar_ld in T0 and T2; pc_inr a single pulse in T1.
- mem_rdata=16'hB1A3 acked after 3 wait cycles -> ir=B1A3, i_bit=1, d=8'b0000_1000, pc_inr exactly one cycle.
- In EXEC, SC_CLR after T5 -> next cycle t[0]; second fetch completes; two pc_inr pulses total.
- ACK_TIMEOUT=4, mem_ack never asserted -> err=1 after 4 T1 waits; running=0; a later START is ignored until CLR.
- HLT and mem_ack in the same T1 cycle -> IDLE, ir unchanged, pc_inr=0.
- CLR asserted mid-T1 between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
